// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: memory geometry and the PRGA state encoding.
package rc4_pkg;

    localparam int unsigned RC4_DW  = 8;
    localparam int unsigned RC4_AW  = 8;
    localparam logic [7:0]  LEN_IDX = 8'd0;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RDLEN,
        S_CAPLEN,
        S_WRLEN,
        S_RDSI,
        S_CAPSI,
        S_RDSJ,
        S_CAPSJ,
        S_WRSI,
        S_WRSJ,
        S_RDPAD,
        S_CAPPAD,
        S_WRPT
    } prga_state_t;

endpackage

// File: rtl/prga.sv
// RC4 pseudo-random generation and decrypt stage. Walks the permuted S memory,
// XORs each ciphertext byte with the keystream and writes length-prefixed plaintext.
// Outputs are registered from the next state so the Moore decode appears on the
// same cycle the state is entered, and reset clears them asynchronously.
module prga
    import rc4_pkg::*;
#(
    parameter int unsigned DATA_W = RC4_DW,
    parameter int unsigned ADDR_W = RC4_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              rdy,
    output logic [ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0] s_rddata,
    output logic [DATA_W-1:0] s_wrdata,
    output logic              s_wren,
    output logic [ADDR_W-1:0] ct_addr,
    input  logic [DATA_W-1:0] ct_rddata,
    output logic [ADDR_W-1:0] pt_addr,
    output logic [DATA_W-1:0] pt_wrdata,
    output logic              pt_wren
);

    prga_state_t state, state_d;

    logic [ADDR_W-1:0] i, i_d;
    logic [ADDR_W-1:0] j, j_d;
    logic [ADDR_W-1:0] k, k_d;
    logic [DATA_W-1:0] len, len_d;
    logic [DATA_W-1:0] si, si_d;
    logic [DATA_W-1:0] sj, sj_d;
    logic [DATA_W-1:0] pt_byte, pt_byte_d;

    logic              rdy_d;
    logic [ADDR_W-1:0] s_addr_d;
    logic [DATA_W-1:0] s_wrdata_d;
    logic              s_wren_d;
    logic [ADDR_W-1:0] ct_addr_d;
    logic [ADDR_W-1:0] pt_addr_d;
    logic [DATA_W-1:0] pt_wrdata_d;
    logic              pt_wren_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Datapath registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i         <= '0;
            j         <= '0;
            k         <= '0;
            len       <= '0;
            si        <= '0;
            sj        <= '0;
            pt_byte   <= '0;
            rdy       <= 1'b1;
            s_addr    <= '0;
            s_wrdata  <= '0;
            s_wren    <= 1'b0;
            ct_addr   <= '0;
            pt_addr   <= '0;
            pt_wrdata <= '0;
            pt_wren   <= 1'b0;
        end else begin
            i         <= i_d;
            j         <= j_d;
            k         <= k_d;
            len       <= len_d;
            si        <= si_d;
            sj        <= sj_d;
            pt_byte   <= pt_byte_d;
            rdy       <= rdy_d;
            s_addr    <= s_addr_d;
            s_wrdata  <= s_wrdata_d;
            s_wren    <= s_wren_d;
            ct_addr   <= ct_addr_d;
            pt_addr   <= pt_addr_d;
            pt_wrdata <= pt_wrdata_d;
            pt_wren   <= pt_wren_d;
        end
    end

    // Next-state, datapath update, and output decode of the next state
    always_comb begin
        state_d     = state;
        i_d         = i;
        j_d         = j;
        k_d         = k;
        len_d       = len;
        si_d        = si;
        sj_d        = sj;
        pt_byte_d   = pt_byte;
        rdy_d       = 1'b0;
        s_addr_d    = '0;
        s_wrdata_d  = '0;
        s_wren_d    = 1'b0;
        ct_addr_d   = '0;
        pt_addr_d   = '0;
        pt_wrdata_d = '0;
        pt_wren_d   = 1'b0;

        case (state)
            S_IDLE: begin
                i_d = '0;
                j_d = '0;
                k_d = ADDR_W'(1);
                if (en) begin
                    state_d = S_RDLEN;
                end
            end
            S_RDLEN: begin
                state_d = S_CAPLEN;
            end
            S_CAPLEN: begin
                len_d   = ct_rddata;
                state_d = S_WRLEN;
            end
            S_WRLEN: begin
                i_d     = i + ADDR_W'(1);
                state_d = (len == '0) ? S_IDLE : S_RDSI;
            end
            S_RDSI: begin
                state_d = S_CAPSI;
            end
            S_CAPSI: begin
                si_d    = s_rddata;
                j_d     = j + ADDR_W'(s_rddata);
                state_d = S_RDSJ;
            end
            S_RDSJ: begin
                state_d = S_CAPSJ;
            end
            S_CAPSJ: begin
                sj_d    = s_rddata;
                state_d = S_WRSI;
            end
            S_WRSI: begin
                state_d = S_WRSJ;
            end
            S_WRSJ: begin
                state_d = S_RDPAD;
            end
            S_RDPAD: begin
                state_d = S_CAPPAD;
            end
            S_CAPPAD: begin
                pt_byte_d = s_rddata ^ ct_rddata;
                state_d   = S_WRPT;
            end
            S_WRPT: begin
                if (k == ADDR_W'(len)) begin
                    state_d = S_IDLE;
                end else begin
                    k_d     = k + ADDR_W'(1);
                    i_d     = i + ADDR_W'(1);
                    state_d = S_RDSI;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        case (state_d)
            S_IDLE: begin
                rdy_d = 1'b1;
            end
            S_RDLEN, S_CAPLEN: begin
                ct_addr_d = ADDR_W'(LEN_IDX);
            end
            S_WRLEN: begin
                pt_addr_d   = ADDR_W'(LEN_IDX);
                pt_wrdata_d = len_d;
                pt_wren_d   = 1'b1;
            end
            S_RDSI, S_CAPSI: begin
                s_addr_d = i_d;
            end
            S_RDSJ, S_CAPSJ: begin
                s_addr_d = j_d;
            end
            S_WRSI: begin
                s_addr_d   = i_d;
                s_wrdata_d = sj_d;
                s_wren_d   = 1'b1;
            end
            S_WRSJ: begin
                s_addr_d   = j_d;
                s_wrdata_d = si_d;
                s_wren_d   = 1'b1;
            end
            S_RDPAD, S_CAPPAD: begin
                s_addr_d  = ADDR_W'(si_d + sj_d);
                ct_addr_d = k_d;
            end
            S_WRPT: begin
                pt_addr_d   = k_d;
                pt_wrdata_d = pt_byte_d;
                pt_wren_d   = 1'b1;
            end
            default: begin
                rdy_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_prga.sv
// Bench for the RC4 PRGA stage: 1-cycle-latency S/CT/PT RAM models and a
// plain RC4 reference model computed from the algorithm definition.
module tb_prga;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       rdy;
    logic [7:0] s_addr, s_rddata, s_wrdata;
    logic       s_wren;
    logic [7:0] ct_addr, ct_rddata;
    logic [7:0] pt_addr, pt_wrdata;
    logic       pt_wren;

    logic [7:0] s_mem  [256];
    logic [7:0] ct_mem [256];
    logic [7:0] pt_mem [256];
    logic [7:0] s_init [256];
    logic [7:0] ct_init[256];
    logic [7:0] m_s    [256];
    logic [7:0] m_pt   [256];
    logic       load;

    int checks = 0;
    int errors = 0;

    prga dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .rdy       (rdy),
        .s_addr    (s_addr),
        .s_rddata  (s_rddata),
        .s_wrdata  (s_wrdata),
        .s_wren    (s_wren),
        .ct_addr   (ct_addr),
        .ct_rddata (ct_rddata),
        .pt_addr   (pt_addr),
        .pt_wrdata (pt_wrdata),
        .pt_wren   (pt_wren)
    );

    always #5 clk = ~clk;

    // RAM models; load copies the staged images in one cycle and poisons PT
    always @(posedge clk) begin
        if (load) begin
            for (int x = 0; x < 256; x++) begin
                s_mem[x]  <= s_init[x];
                ct_mem[x] <= ct_init[x];
                pt_mem[x] <= 8'hEE;
            end
        end else begin
            if (s_wren)  s_mem[s_addr]   <= s_wrdata;
            if (pt_wren) pt_mem[pt_addr] <= pt_wrdata;
        end
        s_rddata  <= s_mem[s_addr];
        ct_rddata <= ct_mem[ct_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Golden RC4 keystream/decrypt over the staged S and CT images
    task automatic model_run();
        int mi, mj, len;
        logic [7:0] t;
        for (int x = 0; x < 256; x++) m_s[x] = s_init[x];
        len = int'(ct_init[0]);
        m_pt[0] = ct_init[0];
        mi = 0;
        mj = 0;
        for (int kk = 1; kk <= len; kk++) begin
            mi = (mi + 1) % 256;
            mj = (mj + int'(m_s[mi])) % 256;
            t = m_s[mi]; m_s[mi] = m_s[mj]; m_s[mj] = t;
            m_pt[kk] = ct_init[kk] ^ m_s[(int'(m_s[mi]) + int'(m_s[mj])) % 256];
        end
    endtask

    // Key scheduling with the 3-byte key "Key"
    task automatic ksa_key();
        logic [7:0] key [3];
        logic [7:0] t;
        int kj;
        key[0] = 8'h4B; key[1] = 8'h65; key[2] = 8'h79;
        for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
        kj = 0;
        for (int x = 0; x < 256; x++) begin
            kj = (kj + int'(s_init[x]) + int'(key[x % 3])) % 256;
            t = s_init[x]; s_init[x] = s_init[kj]; s_init[kj] = t;
        end
    endtask

    task automatic set_ct_vector();
        logic [7:0] v [9];
        v = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        for (int x = 0; x < 256; x++) ct_init[x] = 8'h00;
        ct_init[0] = 8'd9;
        for (int x = 0; x < 9; x++) ct_init[x + 1] = v[x];
    endtask

    task automatic load_mems();
        @(negedge clk); load = 1'b1;
        @(negedge clk); load = 1'b0;
    endtask

    // Pulse en, then count cycles with rdy low (bounded); optional stray en mid-run
    task automatic run(input bit mid, output int low);
        @(negedge clk); en = 1'b1;
        @(negedge clk); en = 1'b0;
        low = 0;
        while (rdy !== 1'b1 && low < 3000) begin
            low++;
            if (mid && low == 10) en = 1'b1;
            if (mid && low == 12) en = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic check_result(input string tag, input int len);
        int bad;
        bad = 0;
        for (int x = 0; x <= len; x++) if (pt_mem[x] !== m_pt[x]) bad++;
        chk({tag, "_pt_words_bad"}, 32'(bad), 32'd0);
        chk({tag, "_pt_len"}, 32'(pt_mem[0]), 32'(len));
        bad = 0;
        for (int x = 0; x < 256; x++) if (s_mem[x] !== m_s[x]) bad++;
        chk({tag, "_s_words_bad"}, 32'(bad), 32'd0);
    endtask

    initial begin
        int low, cnt, bad, r;
        logic [7:0] t;
        string ptxt;

        load = 1'b0;
        en   = 1'b0;
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        chk("rst_rdy", 32'(rdy), 32'd1);
        chk("rst_s_wren", 32'(s_wren), 32'd0);
        chk("rst_pt_wren", 32'(pt_wren), 32'd0);
        chk("rst_addrs", {8'h0, s_addr, ct_addr, pt_addr}, 32'd0);
        chk("rst_wrdata", 32'({s_wrdata, pt_wrdata}), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1: zero-length message
        for (int x = 0; x < 256; x++) begin
            s_init[x]  = 8'($urandom);
            ct_init[x] = 8'($urandom);
        end
        ct_init[0] = 8'd0;
        load_mems();
        model_run();
        run(1'b0, low);
        chk("t1_rdy_low", 32'(low), 32'd3);
        chk("t1_pt1_untouched", 32'(pt_mem[1]), 32'hEE);
        check_result("t1", 0);

        // 2: identity S, single zero byte -> pad is S[2]
        for (int x = 0; x < 256; x++) begin
            s_init[x]  = 8'(x);
            ct_init[x] = 8'h00;
        end
        ct_init[0] = 8'd1;
        load_mems();
        model_run();
        run(1'b0, low);
        chk("t2_rdy_low", 32'(low), 32'd12);
        chk("t2_pt1", 32'(pt_mem[1]), 32'h02);
        check_result("t2", 1);

        // 3: known vector, key "Key"
        ptxt = "Plaintext";
        ksa_key();
        set_ct_vector();
        load_mems();
        model_run();
        run(1'b0, low);
        chk("t3_rdy_low", 32'(low), 32'd84);
        bad = 0;
        for (int x = 0; x < 9; x++) if (pt_mem[x + 1] !== ptxt[x]) bad++;
        chk("t3_plaintext_bad", 32'(bad), 32'd0);
        check_result("t3", 9);

        // 4: max length, random permutation and ciphertext
        for (int x = 0; x < 256; x++) begin
            s_init[x]  = 8'(x);
            ct_init[x] = 8'($urandom);
        end
        for (int x = 255; x > 0; x--) begin
            r = int'($urandom_range(x, 0));
            t = s_init[x]; s_init[x] = s_init[r]; s_init[r] = t;
        end
        ct_init[0] = 8'd255;
        load_mems();
        model_run();
        run(1'b0, low);
        chk("t4_rdy_low", 32'(low), 32'd2298);
        check_result("t4", 255);

        // 5: stray en while busy is ignored; rdy stays high afterwards
        ksa_key();
        set_ct_vector();
        load_mems();
        model_run();
        run(1'b1, low);
        chk("t5_rdy_low", 32'(low), 32'd84);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rdy !== 1'b1 || pt_wren !== 1'b0) cnt++;
        end
        chk("t5_no_restart", 32'(cnt), 32'd0);
        check_result("t5", 9);

        // 6: reset at WRSI of byte 4 aborts immediately
        ksa_key();
        set_ct_vector();
        load_mems();
        @(negedge clk); en = 1'b1;
        @(negedge clk); en = 1'b0;
        cnt = 0;
        low = 0;
        while (cnt < 7 && low < 200) begin
            if (s_wren === 1'b1) cnt++;
            if (cnt < 7) begin
                @(negedge clk);
                low++;
            end
        end
        chk("t6_reach_wrsi4", 32'(cnt), 32'd7);
        chk("t6_pre_wren", 32'(s_wren), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_abort_s_wren", 32'(s_wren), 32'd0);
        chk("t6_abort_rdy", 32'(rdy), 32'd1);
        chk("t6_abort_pt_wren", 32'(pt_wren), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ksa_key();
        load_mems();
        model_run();
        run(1'b0, low);
        chk("t6_rerun_rdy_low", 32'(low), 32'd84);
        bad = 0;
        for (int x = 0; x < 9; x++) if (pt_mem[x + 1] !== ptxt[x]) bad++;
        chk("t6_rerun_plaintext_bad", 32'(bad), 32'd0);
        check_result("t6", 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
